// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: lsu_mode bit positions,
// access-size encodings and FSM state codes.
package lsu_pkg;

  localparam int MODE_LOAD  = 0;
  localparam int MODE_STORE = 1;
  localparam int MODE_SZ_LO = 2;
  localparam int MODE_SZ_HI = 3;
  localparam int MODE_UNS   = 4;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store data replication and byte mask,
// load data extraction with sign/zero extension, and access error detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        zero_ext,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = mem_rdata >> {off, 3'b000};
    wdata     = '0;
    wmask     = '0;
    load_data = shifted;
    case (size)
      SZ_B: begin
        wdata     = {4{store_data[7:0]}};
        wmask     = 4'b0001 << off;
        load_data = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        wdata     = {2{store_data[15:0]}};
        wmask     = 4'b0011 << off;
        load_data = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        wdata     = store_data;
        wmask     = 4'b1111;
      end
      default: ;
    endcase
    // Loads never write, so the lane controls are forced quiet.
    if (!is_store) begin
      wdata = '0;
      wmask = '0;
    end
    misalign = (is_load | is_store) &
               ((is_load & is_store) |
                (size == 2'b11) |
                ((size == SZ_H) & off[0]) |
                ((size == SZ_W) & (off != 2'b00)));
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit behind execute: one outstanding memory request, result
// handed to write-back over valid/ready.
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] EXU_data,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        lsu_mode,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_misalign
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid is never withdrawn and its payload is held until then.

  logic [1:0]        state;
  logic [4:0]        mode_q;
  logic [1:0]        off_q;
  logic              is_idle;
  logic [4:0]        cur_mode;
  logic [1:0]        cur_off;
  logic [DATA_W-1:0] al_wdata;
  logic [3:0]        al_wmask;
  logic [DATA_W-1:0] al_load;
  logic              al_misalign;

  assign is_idle       = (state == ST_IDLE);
  assign in_ready      = is_idle;
  assign mem_req_valid = (state == ST_REQ);
  assign out_valid     = (state == ST_OUT);

  // In IDLE the aligner decodes the incoming instruction; afterwards it works
  // on the latched copy so load extraction sees the original offset and size.
  assign cur_mode = is_idle ? lsu_mode : mode_q;
  assign cur_off  = is_idle ? EXU_data[1:0] : off_q;

  lsu_align u_align (
    .size       (cur_mode[MODE_SZ_HI:MODE_SZ_LO]),
    .off        (cur_off),
    .zero_ext   (cur_mode[MODE_UNS]),
    .is_load    (cur_mode[MODE_LOAD]),
    .is_store   (cur_mode[MODE_STORE]),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .wdata      (al_wdata),
    .wmask      (al_wmask),
    .load_data  (al_load),
    .misalign   (al_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mode_q       <= '0;
      off_q        <= '0;
      mem_addr     <= '0;
      mem_wen      <= 1'b0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
      out_data     <= '0;
      out_misalign <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mode_q <= lsu_mode;
            off_q  <= EXU_data[1:0];
            if (!(lsu_mode[MODE_LOAD] | lsu_mode[MODE_STORE])) begin
              out_data     <= EXU_data;
              out_misalign <= 1'b0;
              state        <= ST_OUT;
            end else if (al_misalign) begin
              out_data     <= '0;
              out_misalign <= 1'b1;
              state        <= ST_OUT;
            end else begin
              mem_addr     <= {EXU_data[ADDR_W-1:2], 2'b00};
              mem_wen      <= lsu_mode[MODE_STORE];
              mem_wdata    <= al_wdata;
              mem_wmask    <= al_wmask;
              out_misalign <= 1'b0;
              state        <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) state <= ST_RSP;
        end
        ST_RSP: begin
          // Stores carry no result; the acknowledge only releases the slot.
          if (mem_rsp_valid) begin
            out_data <= mode_q[MODE_LOAD] ? al_load : '0;
            state    <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed scenarios plus randomized
// transactions compared against a behavioural model of the access rules.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] EXU_data;
  logic [31:0] store_data;
  logic [4:0]  lsu_mode;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .EXU_data(EXU_data), .store_data(store_data), .lsu_mode(lsu_mode),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_misalign(out_misalign)
  );

  typedef struct {
    bit          got_req;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    int          n_req;
    bit          req_unstable;
    bit          got_out;
    int          out_cycle;
    logic [31:0] out_data;
    logic        out_mis;
    bit          out_unstable;
    bit          ready_leak;
    bit          timeout;
    logic        ready_at_start;
    logic        ready_after;
    logic        valid_after;
  } obs_t;

  typedef struct {
    bit          mem;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  // Reference: decode the access from the architectural rules directly.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] sd,
                                 input logic [4:0] m, input logic [31:0] rd);
    exp_t e;
    int off = int'(a % 4);
    int sz = int'(m[3:2]);
    logic [31:0] v;
    e = '{default: 0};
    if (!m[0] && !m[1]) begin
      e.data = a;
      return e;
    end
    if ((m[0] && m[1]) || sz == 3 || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0)) begin
      e.mis = 1'b1;
      return e;
    end
    e.mem  = 1'b1;
    e.addr = a - 32'(off);
    e.wen  = m[1];
    if (m[1]) begin
      if (sz == 0) begin e.wdata = 32'(sd[7:0]) * 32'h0101_0101; e.wmask = 4'(1 << off); end
      else if (sz == 1) begin e.wdata = 32'(sd[15:0]) * 32'h0001_0001; e.wmask = 4'(3 << off); end
      else begin e.wdata = sd; e.wmask = 4'hF; end
    end else begin
      v = rd >> (8 * off);
      if (sz == 0) begin
        v = v % 256;
        if (!m[4] && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (sz == 1) begin
        v = v % 65536;
        if (!m[4] && v >= 32768) v = v + 32'hFFFF_0000;
      end
      e.data = v;
    end
    return e;
  endfunction

  // Drive one instruction and act as the memory and write-back stage.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] m,
                        input logic [31:0] rd, input int req_stall, input int out_stall,
                        output obs_t o);
    int rs = req_stall;
    int os = out_stall;
    bit rsp_due = 0;
    bit done = 0;
    o = '{default: 0};
    @(negedge clk);
    o.ready_at_start = in_ready;
    in_valid = 1'b1; EXU_data = a; store_data = sd; lsu_mode = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0; EXU_data = $urandom; store_data = $urandom; lsu_mode = 5'($urandom);
    for (int k = 1; k <= 100 && !done; k++) begin
      @(negedge clk);
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; out_ready = 1'b0; mem_rdata = $urandom;
      if (rsp_due) begin mem_rsp_valid = 1'b1; mem_rdata = rd; rsp_due = 0; end
      if (mem_req_valid) begin
        if (!o.got_req) begin
          o.got_req = 1; o.req_addr = mem_addr; o.req_wen = mem_wen;
          o.req_wdata = mem_wdata; o.req_wmask = mem_wmask;
        end else if (mem_addr !== o.req_addr || mem_wen !== o.req_wen ||
                     mem_wdata !== o.req_wdata || mem_wmask !== o.req_wmask) begin
          o.req_unstable = 1;
        end
        if (rs > 0) begin
          rs--;
          mem_rsp_valid = 1'($urandom_range(0, 1));
        end else begin
          mem_req_ready = 1'b1; o.n_req++; rsp_due = 1;
        end
      end
      if (in_ready !== 1'b0) o.ready_leak = 1;
      if (out_valid) begin
        if (!o.got_out) begin
          o.got_out = 1; o.out_cycle = k; o.out_data = out_data; o.out_mis = out_misalign;
        end else if (out_data !== o.out_data || out_misalign !== o.out_mis) begin
          o.out_unstable = 1;
        end
        if (os > 0) os--;
        else begin out_ready = 1'b1; done = 1; end
      end
    end
    if (!done) o.timeout = 1;
    @(negedge clk);
    out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    o.ready_after = in_ready;
    o.valid_after = out_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; EXU_data = '0; store_data = '0; lsu_mode = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if ({mem_req_valid, mem_wen, out_valid, out_misalign} !== 4'b0) begin errors++;
      $display("FAIL rst_flags got=%b exp=0000", {mem_req_valid, mem_wen, out_valid, out_misalign}); end
    checks++; if ({mem_addr, mem_wdata, mem_wmask, out_data} !== 100'b0) begin errors++;
      $display("FAIL rst_regs got=%h/%h/%h/%h exp=0", mem_addr, mem_wdata, mem_wmask, out_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough;
    obs_t o;
    do_txn(32'h1234_5678, 32'h0, 5'b00000, 32'h0, 0, 0, o);
    checks++; if (o.timeout) begin errors++; $display("FAIL pt_timeout got=1 exp=0"); end
    checks++; if (o.out_cycle !== 1) begin errors++; $display("FAIL pt_latency got=%0d exp=1", o.out_cycle); end
    checks++; if (o.out_data !== 32'h1234_5678) begin errors++; $display("FAIL pt_data got=%h exp=12345678", o.out_data); end
    checks++; if (o.got_req || o.out_mis) begin errors++; $display("FAIL pt_no_mem got=%b/%b exp=0/0", o.got_req, o.out_mis); end
  endtask

  task automatic test_byte_load;
    obs_t o;
    do_txn(32'h8000_0003, 32'h0, 5'b00001, 32'h80AB_CDEF, 0, 0, o);
    checks++; if (o.req_addr !== 32'h8000_0000 || o.req_wen !== 1'b0 || o.req_wmask !== 4'h0) begin errors++;
      $display("FAIL lb_req got=%h/%b/%b exp=80000000/0/0000", o.req_addr, o.req_wen, o.req_wmask); end
    checks++; if (o.out_cycle !== 3) begin errors++; $display("FAIL lb_latency got=%0d exp=3", o.out_cycle); end
    checks++; if (o.out_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed got=%h exp=ffffff80", o.out_data); end
    do_txn(32'h8000_0003, 32'h0, 5'b10001, 32'h80AB_CDEF, 0, 0, o);
    checks++; if (o.out_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got=%h exp=00000080", o.out_data); end
  endtask

  task automatic test_half_store;
    obs_t o;
    do_txn(32'h0000_0102, 32'hDEAD_BEEF, 5'b00110, 32'h0, 2, 0, o);
    checks++; if (o.req_addr !== 32'h0000_0100 || o.req_wen !== 1'b1) begin errors++;
      $display("FAIL sh_addr got=%h/%b exp=00000100/1", o.req_addr, o.req_wen); end
    checks++; if (o.req_wdata !== 32'hBEEF_BEEF || o.req_wmask !== 4'b1100) begin errors++;
      $display("FAIL sh_lanes got=%h/%b exp=beefbeef/1100", o.req_wdata, o.req_wmask); end
    checks++; if (o.out_cycle !== 5 || o.out_mis !== 1'b0) begin errors++;
      $display("FAIL sh_ack_wait got=%0d/%b exp=5/0", o.out_cycle, o.out_mis); end
  endtask

  task automatic test_misaligned;
    obs_t o;
    do_txn(32'h0000_0006, 32'h0, 5'b01001, 32'h0, 0, 0, o);
    checks++; if (o.got_req) begin errors++; $display("FAIL mis_no_req got=1 exp=0"); end
    checks++; if (o.out_cycle !== 1 || o.out_mis !== 1'b1 || o.out_data !== 32'h0) begin errors++;
      $display("FAIL mis_out got=%0d/%b/%h exp=1/1/00000000", o.out_cycle, o.out_mis, o.out_data); end
  endtask

  task automatic test_backpressure;
    obs_t o;
    do_txn(32'h0000_0040, 32'h5555_AAAA, 5'b01001, 32'h1357_9BDF, 5, 3, o);
    checks++; if (o.req_unstable || o.out_unstable) begin errors++;
      $display("FAIL bp_stable got=%b/%b exp=0/0", o.req_unstable, o.out_unstable); end
    checks++; if (o.n_req !== 1) begin errors++; $display("FAIL bp_one_req got=%0d exp=1", o.n_req); end
    checks++; if (o.ready_leak) begin errors++; $display("FAIL bp_in_ready got=1 exp=0"); end
    checks++; if (o.out_cycle !== 8 || o.out_data !== 32'h1357_9BDF) begin errors++;
      $display("FAIL bp_out got=%0d/%h exp=8/13579bdf", o.out_cycle, o.out_data); end
    checks++; if (o.ready_after !== 1'b1 || o.valid_after !== 1'b0) begin errors++;
      $display("FAIL bp_release got=%b/%b exp=1/0", o.ready_after, o.valid_after); end
  endtask

  task automatic test_random;
    obs_t o;
    exp_t e;
    logic [31:0] a, sd, rd;
    logic [4:0] m;
    logic [1:0] sz;
    int op, rs, os, exp_cyc;
    for (int n = 0; n < 60; n++) begin
      a = $urandom; sd = $urandom; rd = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      op = $urandom_range(0, 9);
      sz = ($urandom_range(0, 7) == 7) ? 2'b11 : 2'($urandom_range(0, 2));
      m = {1'($urandom_range(0, 1)), sz, 2'b00};
      if (op >= 2 && op <= 5) m[0] = 1'b1;
      else if (op >= 6 && op <= 8) m[1] = 1'b1;
      else if (op == 9) m[1:0] = 2'b11;
      rs = $urandom_range(0, 3); os = $urandom_range(0, 2);
      e = model(a, sd, m, rd);
      do_txn(a, sd, m, rd, rs, os, o);
      exp_cyc = e.mem ? 3 + rs : 1;
      checks++; if (o.timeout || o.out_cycle !== exp_cyc) begin errors++;
        $display("FAIL rnd_latency n=%0d got=%0d exp=%0d", n, o.out_cycle, exp_cyc); end
      checks++; if (o.out_mis !== e.mis || o.got_req !== e.mem) begin errors++;
        $display("FAIL rnd_kind n=%0d mode=%b got=%b/%b exp=%b/%b", n, m, o.out_mis, o.got_req, e.mis, e.mem); end
      if (!(e.mem && e.wen)) begin
        checks++; if (o.out_data !== e.data) begin errors++;
          $display("FAIL rnd_data n=%0d mode=%b a=%h got=%h exp=%h", n, m, a, o.out_data, e.data); end
      end
      if (e.mem) begin
        checks++; if (o.req_addr !== e.addr || o.req_wen !== e.wen || o.req_wmask !== e.wmask || o.n_req !== 1) begin errors++;
          $display("FAIL rnd_req n=%0d got=%h/%b/%b/%0d exp=%h/%b/%b/1", n, o.req_addr, o.req_wen, o.req_wmask, o.n_req, e.addr, e.wen, e.wmask); end
        if (e.wen) begin
          checks++; if (o.req_wdata !== e.wdata) begin errors++;
            $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, o.req_wdata, e.wdata); end
        end
      end
      checks++; if (o.req_unstable || o.out_unstable || o.ready_leak || o.ready_at_start !== 1'b1) begin errors++;
        $display("FAIL rnd_protocol n=%0d got=%b%b%b%b exp=0001", n, o.req_unstable, o.out_unstable, o.ready_leak, o.ready_at_start); end
    end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    // Reset while the request is pending: valid must drop without a clock edge.
    @(negedge clk);
    in_valid = 1'b1; EXU_data = 32'h0000_0200; lsu_mode = 5'b01001;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rm_req_up got=%b exp=1", mem_req_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL rm_async_drop got=%b/%b exp=0/1", mem_req_valid, in_ready); end
    @(negedge clk); rst_n = 1'b1;
    // Reset while waiting for the response.
    @(negedge clk);
    in_valid = 1'b1; EXU_data = 32'h0000_0304; lsu_mode = 5'b01001;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); mem_req_ready = 1'b1;
    @(negedge clk); mem_req_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({mem_req_valid, mem_wen, out_valid, out_misalign} !== 4'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL rsp_rst_flags got=%b/%b exp=0000/1", {mem_req_valid, mem_wen, out_valid, out_misalign}, in_ready); end
    checks++; if ({mem_addr, mem_wdata, mem_wmask, out_data} !== 100'b0) begin errors++;
      $display("FAIL rsp_rst_regs got=%h/%h/%h/%h exp=0", mem_addr, mem_wdata, mem_wmask, out_data); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk); mem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
        $display("FAIL rsp_spurious i=%0d got=%b/%b exp=0/1", i, out_valid, in_ready); end
      @(negedge clk);
    end
    do_txn(32'h0000_0100, 32'h0, 5'b01001, 32'hCAFE_F00D, 0, 0, o);
    checks++; if (o.timeout || o.out_data !== 32'hCAFE_F00D || o.out_cycle !== 3) begin errors++;
      $display("FAIL rm_next_load got=%h/%0d exp=cafef00d/3", o.out_data, o.out_cycle); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
